// File: rtl/scope_pio_edge_gen2.sv
// rtl/scope_pio_edge_gen2.sv - Avalon-MM input PIO with per-bit edge capture, irq and event counter
// Optional input debounce filter: define SCOPE_PIO_DEBOUNCE_EN.
module scope_pio_edge_gen2 #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [15:0]      event_count;

    logic [WIDTH-1:0] edge_hit;
    logic             any_edge;
    logic             wr;
    logic [31:0]      rd_mux;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef SCOPE_PIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    // Each bit follows sync2 only after it has disagreed with filt for DEBOUNCE_CYCLES cycles in a row.
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        logic [CW-1:0] db_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                db_cnt  <= '0;
                filt[i] <= 1'b0;
            end else if (sync2[i] == filt[i]) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt  <= '0;
                filt[i] <= sync2[i];
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end
`else
    assign filt = sync2;
`endif

    assign edge_hit = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
    assign any_edge = |edge_hit;
    assign wr       = chipselect && !write_n;
    assign irq      = |(edge_capture & irq_mask);

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = filt;
            3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            3'd4:    rd_mux[WIDTH-1:0] = rise_en;
            3'd5:    rd_mux[WIDTH-1:0] = fall_en;
            3'd6:    rd_mux[15:0]      = event_count;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            rise_en      <= '0;
            fall_en      <= '1;
            event_count  <= '0;
            readdata     <= '0;
        end else begin
            prev     <= filt;
            readdata <= rd_mux;

            if (wr && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 3'd4) rise_en  <= writedata[WIDTH-1:0];
            if (wr && address == 3'd5) fall_en  <= writedata[WIDTH-1:0];

            // A new edge wins over a coincident clear so no event is lost.
            if (wr && address == 3'd3)
                edge_capture <= (edge_capture & ~writedata[WIDTH-1:0]) | edge_hit;
            else
                edge_capture <= edge_capture | edge_hit;

            if (wr && address == 3'd6)
                event_count <= any_edge ? 16'd1 : 16'd0;
            else if (any_edge && event_count != 16'hFFFF)
                event_count <= event_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_scope_pio_edge_gen2.sv
// tb/tb_scope_pio_edge_gen2.sv - directed self-checking bench for scope_pio_edge_gen2 (default build)
module tb_scope_pio_edge_gen2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [5:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    scope_pio_edge_gen2 #(.WIDTH(6), .DEBOUNCE_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        tick();
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 6'h3F;
        tick(2);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick(4);
        rd(3'd5, 32'h3F, "reset_fall_en");
        rd(3'd4, 32'h00, "reset_rise_en");
        rd(3'd3, 32'h00, "reset_capture_no_rise");

        // Test 1: falling edge on bit 0 with default FALL_EN
        address = 3'd3;
        in_port = 6'h3E;
        tick(2);
        chk("t1_capture_before_k2", readdata, 32'h0);
        tick();
        chk("t1_irq_masked", {31'b0, irq}, 32'h0);
        tick();
        chk("t1_capture_after_k2", readdata, 32'h01);
        rd(3'd0, 32'h3E, "t1_data");
        wr(3'd2, 32'h01);
        chk("t1_irq_unmasked", {31'b0, irq}, 32'h1);
        wr(3'd3, 32'h01);
        chk("t1_irq_cleared", {31'b0, irq}, 32'h0);
        rd(3'd3, 32'h00, "t1_capture_cleared");
        rd(3'd6, 32'h01, "t1_count");
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, 32'h0, "t1_addr1_zero");
        rd(3'd7, 32'h0, "t1_addr7_zero");

        // Test 2: rise-only mode, then add fall on bit 2
        wr(3'd5, 32'h00);
        wr(3'd4, 32'h00);
        in_port = 6'h00;
        tick(4);
        wr(3'd3, 32'h3F);
        wr(3'd6, 32'h0);
        wr(3'd4, 32'h3F);
        in_port = 6'h04;
        tick(2);
        in_port = 6'h00;
        tick(4);
        rd(3'd3, 32'h04, "t2_capture_rise");
        rd(3'd6, 32'h01, "t2_count_rise_only");
        wr(3'd5, 32'h04);
        wr(3'd3, 32'h3F);
        in_port = 6'h04;
        tick(2);
        in_port = 6'h00;
        tick(4);
        rd(3'd6, 32'h03, "t2_count_rise_fall");
        rd(3'd3, 32'h04, "t2_capture_rise_fall");

        // Test 3: W1C and counter clear colliding with a new edge
        wr(3'd3, 32'h3F);
        in_port = 6'h01;
        tick(2);
        wr(3'd3, 32'h01);
        rd(3'd3, 32'h01, "t3_capture_collision");
        in_port = 6'h03;
        tick(2);
        wr(3'd6, 32'h0);
        rd(3'd6, 32'h01, "t3_count_collision");
        rd(3'd3, 32'h03, "t3_capture_both");

        // Test 4: counter saturation
        wr(3'd5, 32'h08);
        for (int i = 0; i < 70000; i++) begin
            in_port[3] = ~in_port[3];
            tick();
        end
        tick(4);
        rd(3'd6, 32'hFFFF, "t4_saturated");
        for (int i = 0; i < 10; i++) begin
            in_port[3] = ~in_port[3];
            tick();
        end
        tick(4);
        rd(3'd6, 32'hFFFF, "t4_holds");
        wr(3'd6, 32'h0);
        rd(3'd6, 32'h0, "t4_cleared");

        // Test 5: reset in the middle of operation
        wr(3'd5, 32'h00);
        wr(3'd4, 32'h00);
        in_port = 6'h00;
        tick(4);
        wr(3'd3, 32'h3F);
        wr(3'd6, 32'h0);
        wr(3'd4, 32'h2A);
        for (int i = 0; i < 5; i++) begin
            in_port = 6'h2A;
            tick(3);
            in_port = 6'h00;
            tick(3);
        end
        wr(3'd2, 32'h3F);
        chk("t5_irq_pre", {31'b0, irq}, 32'h1);
        rd(3'd3, 32'h2A, "t5_capture_pre");
        rd(3'd6, 32'h05, "t5_count_pre");
        address = 3'd6;
        in_port = 6'h2A;
        reset   = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_irq_post", {31'b0, irq}, 32'h0);
        chk("t5_readdata_post", readdata, 32'h0);
        rd(3'd5, 32'h3F, "t5_fall_en");
        rd(3'd2, 32'h00, "t5_mask");
        rd(3'd4, 32'h00, "t5_rise_en");
        tick(3);
        rd(3'd3, 32'h00, "t5_capture");
        rd(3'd6, 32'h00, "t5_count");
        rd(3'd0, 32'h2A, "t5_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
